// File: rtl/ren_tile_rasterizer_if.sv
// rtl/ren_tile_rasterizer_if.sv - triangle input and tile output bundle for the tile rasterizer
interface ren_tile_rasterizer_if #(
  parameter int W = 22
);
  logic                i_en;
  logic                i_valid;
  logic                o_ready;
  logic signed [W-1:0] i_e0_a;
  logic signed [W-1:0] i_e0_b;
  logic signed [W-1:0] i_e0_c;
  logic signed [W-1:0] i_e1_a;
  logic signed [W-1:0] i_e1_b;
  logic signed [W-1:0] i_e1_c;
  logic signed [W-1:0] i_e2_a;
  logic signed [W-1:0] i_e2_b;
  logic signed [W-1:0] i_e2_c;
  logic [W-1:0]        i_min_x;
  logic [W-1:0]        i_max_x;
  logic [W-1:0]        i_min_y;
  logic [W-1:0]        i_max_y;
  logic                o_valid;
  logic                i_ready;
  logic [W-1:0]        o_tile_x;
  logic [W-1:0]        o_tile_y;
  logic                o_full;
  logic                o_busy;
  logic                o_done;

  modport slave (
    input  i_en, i_valid,
    input  i_e0_a, i_e0_b, i_e0_c, i_e1_a, i_e1_b, i_e1_c, i_e2_a, i_e2_b, i_e2_c,
    input  i_min_x, i_max_x, i_min_y, i_max_y, i_ready,
    output o_ready, o_valid, o_tile_x, o_tile_y, o_full, o_busy, o_done
  );

  modport master (
    output i_en, i_valid,
    output i_e0_a, i_e0_b, i_e0_c, i_e1_a, i_e1_b, i_e1_c, i_e2_a, i_e2_b, i_e2_c,
    output i_min_x, i_max_x, i_min_y, i_max_y, i_ready,
    input  o_ready, o_valid, o_tile_x, o_tile_y, o_full, o_busy, o_done
  );
endinterface

// File: rtl/ren_tile_rasterizer.sv
// rtl/ren_tile_rasterizer.sv - tile-walking triangle rasterizer with corner-based tile classification
module ren_tile_rasterizer #(
  parameter int W         = 22,
  parameter int TILE_LOG2 = 3
) (
  input logic                  clk,
  input logic                  rst,
  ren_tile_rasterizer_if.slave bus
);
  localparam int ACC_W = 2 * W + TILE_LOG2 + 2;
  localparam logic [W-1:0] TILE_SZ  = W'(1 << TILE_LOG2);
  localparam logic [W-1:0] LOW_MASK = W'((1 << TILE_LOG2) - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_EVAL, S_OUT, S_DONE} state_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  function automatic acc_t sx(input logic [W-1:0] v);
    return acc_t'({{(ACC_W - W){v[W-1]}}, v});
  endfunction

  function automatic acc_t zx(input logic [W-1:0] v);
    return acc_t'({{(ACC_W - W){1'b0}}, v});
  endfunction

  logic [W-1:0] in_a [3];
  logic [W-1:0] in_b [3];
  logic [W-1:0] in_c [3];

  assign in_a[0] = bus.i_e0_a;
  assign in_b[0] = bus.i_e0_b;
  assign in_c[0] = bus.i_e0_c;
  assign in_a[1] = bus.i_e1_a;
  assign in_b[1] = bus.i_e1_b;
  assign in_c[1] = bus.i_e1_c;
  assign in_a[2] = bus.i_e2_a;
  assign in_b[2] = bus.i_e2_b;
  assign in_c[2] = bus.i_e2_c;

  state_t       state_q, state_d;
  logic [W-1:0] a_q [3], a_d [3];
  logic [W-1:0] b_q [3], b_d [3];
  logic [W-1:0] c_q [3], c_d [3];
  logic [W-1:0] min_x_q, min_x_d, max_x_q, max_x_d;
  logic [W-1:0] min_y_q, min_y_d, max_y_q, max_y_d;
  logic [W-1:0] x0_q, x0_d, y0_q, y0_d;
  acc_t         e_q [3], e_d [3];
  acc_t         row_q [3], row_d [3];
  acc_t         da_q [3], da_d [3];
  acc_t         db_q [3], db_d [3];
  acc_t         ca_q [3], ca_d [3];
  acc_t         cb_q [3], cb_d [3];
  logic [W-1:0] tile_x_q, tile_x_d, tile_y_q, tile_y_d;
  logic         full_q, full_d, valid_q, valid_d;

  acc_t         k1 [3], k2 [3], k3 [3];
  logic         tile_rej, tile_full;

  logic         last_col, last_row, adv_last;
  logic [W-1:0] adv_x, adv_y;
  acc_t         adv_e [3], adv_row [3];

  // Classify the current tile from the four corner values of each edge.
  always_comb begin
    tile_rej  = 1'b0;
    tile_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      k1[k] = e_q[k] + ca_q[k];
      k2[k] = e_q[k] + cb_q[k];
      k3[k] = k1[k] + cb_q[k];
      if (e_q[k][ACC_W-1] & k1[k][ACC_W-1] & k2[k][ACC_W-1] & k3[k][ACC_W-1]) begin
        tile_rej = 1'b1;
      end
      if (e_q[k][ACC_W-1] | k1[k][ACC_W-1] | k2[k][ACC_W-1] | k3[k][ACC_W-1]) begin
        tile_full = 1'b0;
      end
    end
  end

  // Next tile position and edge values in raster order; wraps to the next tile row at row end.
  always_comb begin
    last_col = (x0_q >> TILE_LOG2) == (max_x_q >> TILE_LOG2);
    last_row = (y0_q >> TILE_LOG2) == (max_y_q >> TILE_LOG2);
    adv_last = last_col & last_row;
    adv_x    = x0_q + TILE_SZ;
    adv_y    = y0_q;
    for (int k = 0; k < 3; k++) begin
      adv_e[k]   = e_q[k] + da_q[k];
      adv_row[k] = row_q[k];
    end
    if (last_col) begin
      adv_x = min_x_q & ~LOW_MASK;
      adv_y = y0_q + TILE_SZ;
      for (int k = 0; k < 3; k++) begin
        adv_row[k] = row_q[k] + db_q[k];
        adv_e[k]   = row_q[k] + db_q[k];
      end
    end
  end

  // Next-state and datapath updates; nothing moves while i_en is low.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    min_x_d  = min_x_q;
    max_x_d  = max_x_q;
    min_y_d  = min_y_q;
    max_y_d  = max_y_q;
    x0_d     = x0_q;
    y0_d     = y0_q;
    e_d      = e_q;
    row_d    = row_q;
    da_d     = da_q;
    db_d     = db_q;
    ca_d     = ca_q;
    cb_d     = cb_q;
    tile_x_d = tile_x_q;
    tile_y_d = tile_y_q;
    full_d   = full_q;
    valid_d  = valid_q;
    if (bus.i_en) begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.i_valid) begin
            for (int k = 0; k < 3; k++) begin
              a_d[k] = in_a[k];
              b_d[k] = in_b[k];
              c_d[k] = in_c[k];
            end
            min_x_d = bus.i_min_x;
            max_x_d = bus.i_max_x;
            min_y_d = bus.i_min_y;
            max_y_d = bus.i_max_y;
            state_d = S_SETUP;
          end
        end
        S_SETUP: begin
          x0_d = min_x_q & ~LOW_MASK;
          y0_d = min_y_q & ~LOW_MASK;
          for (int k = 0; k < 3; k++) begin
            da_d[k]  = sx(a_q[k]) <<< TILE_LOG2;
            db_d[k]  = sx(b_q[k]) <<< TILE_LOG2;
            ca_d[k]  = (sx(a_q[k]) <<< TILE_LOG2) - sx(a_q[k]);
            cb_d[k]  = (sx(b_q[k]) <<< TILE_LOG2) - sx(b_q[k]);
            e_d[k]   = zx(x0_d) * sx(a_q[k]) + zx(y0_d) * sx(b_q[k]) + sx(c_q[k]);
            row_d[k] = e_d[k];
          end
          state_d = ((min_x_q > max_x_q) || (min_y_q > max_y_q)) ? S_DONE : S_EVAL;
        end
        S_EVAL: begin
          if (tile_rej) begin
            x0_d    = adv_x;
            y0_d    = adv_y;
            e_d     = adv_e;
            row_d   = adv_row;
            state_d = adv_last ? S_DONE : S_EVAL;
          end else begin
            tile_x_d = x0_q;
            tile_y_d = y0_q;
            full_d   = tile_full;
            valid_d  = 1'b1;
            state_d  = S_OUT;
          end
        end
        S_OUT: begin
          if (bus.i_ready) begin
            valid_d = 1'b0;
            x0_d    = adv_x;
            y0_d    = adv_y;
            e_d     = adv_e;
            row_d   = adv_row;
            state_d = adv_last ? S_DONE : S_EVAL;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers; reset discards any in-flight triangle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '{default: '0};
      b_q      <= '{default: '0};
      c_q      <= '{default: '0};
      min_x_q  <= '0;
      max_x_q  <= '0;
      min_y_q  <= '0;
      max_y_q  <= '0;
      x0_q     <= '0;
      y0_q     <= '0;
      e_q      <= '{default: '0};
      row_q    <= '{default: '0};
      da_q     <= '{default: '0};
      db_q     <= '{default: '0};
      ca_q     <= '{default: '0};
      cb_q     <= '{default: '0};
      tile_x_q <= '0;
      tile_y_q <= '0;
      full_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      min_x_q  <= min_x_d;
      max_x_q  <= max_x_d;
      min_y_q  <= min_y_d;
      max_y_q  <= max_y_d;
      x0_q     <= x0_d;
      y0_q     <= y0_d;
      e_q      <= e_d;
      row_q    <= row_d;
      da_q     <= da_d;
      db_q     <= db_d;
      ca_q     <= ca_d;
      cb_q     <= cb_d;
      tile_x_q <= tile_x_d;
      tile_y_q <= tile_y_d;
      full_q   <= full_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.o_ready  = (state_q == S_IDLE);
  assign bus.o_busy   = (state_q != S_IDLE);
  assign bus.o_done   = (state_q == S_DONE);
  assign bus.o_valid  = valid_q;
  assign bus.o_tile_x = tile_x_q;
  assign bus.o_tile_y = tile_y_q;
  assign bus.o_full   = full_q;
endmodule

// File: doc/ren_tile_rasterizer.md
# ren_tile_rasterizer

Parametrised tile-traversal rasterizer: accepts one triangle as three edge functions E(x,y)=a·x+b·y+c plus a screen bounding box, walks the box in raster order in 2^TILE_LOG2-square tiles, and classifies each tile as full, partial or rejected by incremental edge evaluation at its four corners. Covered tiles are emitted with a valid/ready handshake to the downstream fragment/tile stage; rejected tiles are skipped silently. Sits between triangle setup and per-pixel fragment generation.

## Interface
- W, 22: width of coordinates (unsigned) and edge coefficients a, b, c (signed two's complement).
- TILE_LOG2, 3: log2 of tile edge length T (default T=8).
- ACC_W, 2*W+TILE_LOG2+2 (localparam): signed edge-accumulator width; all edge arithmetic is done at this width, with no overflow for any in-range input.

- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_en  in  1  global enable; when low, all state, including outputs, holds.
- i_valid  in  1  triangle present on inputs.
- o_ready  out  1  block can accept a triangle (high only in IDLE).
- i_e0_a/b/c, i_e1_a/b/c, i_e2_a/b/c  in  W each  signed edge coefficients.
- i_min_x, i_max_x, i_min_y, i_max_y  in  W each  inclusive pixel bounding box.
- o_valid  out  1  tile output valid.
- i_ready  in  1  downstream accepts tile.
- o_tile_x, o_tile_y  out  W each  tile origin, low TILE_LOG2 bits zero.
- o_full  out  1  1 = all T×T pixels inside, 0 = partial.
- o_busy  out  1  state != IDLE.
- o_done  out  1  one-cycle pulse after the triangle's last tile is resolved.

## Operation
- Pixel (x,y) is inside iff E0, E1 and E2 are all >= 0 at (x,y).
- States: IDLE, SETUP, EVAL, OUT, DONE.
- IDLE: o_ready=1. i_valid & o_ready & i_en latches all inputs, then goes to SETUP.
- SETUP (1 cycle):
  - x0 = min_x & ~(T-1), y0 = min_y & ~(T-1).
  - Per edge: E = a·x0 + b·y0 + c. Keep a row-start copy of E.
  - Per edge: step values da = a<<L and db = b<<L; corner offsets ca = da-a and cb = db-b.
  - If min_x > max_x or min_y > max_y, go to DONE with no tiles. Otherwise go to EVAL.
- EVAL (1 cycle per tile):
  - Corners per edge: E, E+ca, E+cb, E+ca+cb.
  - Reject: any edge has all four corners < 0.
  - Full: all 12 corners >= 0.
  - Otherwise the tile is partial.
  - On reject, advance in the same cycle. If not rejected, register o_tile_x/y and o_full, assert o_valid, and go to OUT.
- OUT: hold o_valid and tile fields stable until i_ready. On the handshake cycle, drop o_valid, advance and return to EVAL (or DONE).
- Advance:
  - If (x0>>L) != (max_x>>L): x0 += T and E += da.
  - Otherwise, at row end: x0 = min_x-aligned, row_E += db, E = row_E, y0 += T.
  - If (y0>>L) == (max_y>>L) at row end, the last tile is resolved: go to DONE.
- DONE (1 cycle): o_done=1, then go to IDLE.
- Tile order is row-major, left-to-right, top-to-bottom. Every tile intersecting the box is evaluated exactly once.

## Timing
- Reset values: state IDLE; o_ready=1, o_valid=0, o_full=0, o_tile_x=0, o_tile_y=0, o_busy=0, o_done=0.
- Triangle accepted in cycle N:
  - SETUP in N+1.
  - First EVAL in N+2.
  - First o_valid earliest in N+3.
- Rejected tile: 1 cycle. Emitted tile: 2 cycles minimum (EVAL + OUT with i_ready=1).
- Degenerate box: o_done in N+2, back in IDLE at N+3.
- o_valid never drops without i_ready; o_tile_x/y and o_full are stable while o_valid & !i_ready.
- i_en low freezes all state, including the handshake: an i_ready during i_en=0 is ignored.
- rst mid-traversal: the next cycle is IDLE with all outputs at reset values; the in-flight triangle is discarded and no o_done is issued.
- i_valid outside IDLE is ignored (o_ready=0).

## Test plan
- Constant-inside edges (a=b=0, c=1), box 0..15 × 0..15, i_ready=1 -> 4 tiles (0,0), (8,0), (0,8), (8,8), all with o_full=1, then a single o_done.
- Edge0 a=-1, b=0, c=10, other edges constant 1, box 0..15 × 0..7 -> (0,0) with o_full=1, (8,0) with o_full=0 (corners 2, -5).
- Edge0 a=b=0, c=-1, box 0..15 × 0..15 -> no o_valid; o_done exactly 6 cycles after accept (SETUP + 4 EVAL + DONE).
- Unaligned box min_x=5, max_x=9, min_y=max_y=3 -> tiles (0,0), (8,0). Degenerate box min_x=20, max_x=10 -> zero tiles, o_done at accept+2.
- i_ready held low 5 cycles on the first tile -> o_valid and fields stable throughout, no tile skipped or duplicated. Toggling i_en low mid-stream -> the output sequence is identical to the uninterrupted run.
- rst asserted during OUT of tile 2 -> next cycle o_valid=0, o_busy=0, o_ready=1. A new triangle is then processed correctly from its first tile.
